quad_step_decoder: RTL

Decodes a two-phase quadrature or Gray-coded input pair (A/B) into single-cycle up/down step strobes.
It is the upstream producer for a roll-over position counter's up/down inputs, and sits between raw encoder pins and the position or counter logic.
Provides input synchronisation, glitch filtering, illegal-transition detection and a saturating error count.

---
 rtl/quad_step_decoder_pkg.sv | 35 +++
 rtl/quad_step_decoder_glitch_filter.sv | 48 ++++
 rtl/quad_step_decoder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/quad_step_decoder_pkg.sv
// Shared types and the Gray-step classifier for the quadrature step decoder.
package qdec_pkg;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DOWN,
    STEP_ERR
  } step_e;

  typedef enum logic {
    S_INIT,
    S_RUN
  } fsm_e;

  // Position of an {A,B} pair along the forward cycle 00->01->11->10.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  // Classify the move between two filtered {A,B} samples.
  function automatic step_e gray_step(input logic [1:0] prev, input logic [1:0] next);
    logic [1:0] diff;
    step_e      step;
    diff = gray_pos(next) - gray_pos(prev);
    case (diff)
      2'd0:    step = STEP_NONE;
      2'd1:    step = STEP_UP;
      2'd3:    step = STEP_DOWN;
      default: step = STEP_ERR;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/quad_step_decoder_glitch_filter.sv
// Per-phase synchroniser plus stability filter; load_i bypasses the filter
// so the decoder can adopt the current pin level at start-up.
module glitch_filter #(
  parameter int unsigned SyncStages   = 2,
  parameter int unsigned FilterCycles = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  input  logic load_i,
  output logic sync_o,
  output logic filt_o
);

  localparam int unsigned CntW = (FilterCycles > 1) ? $clog2(FilterCycles) : 1;

  logic [SyncStages-1:0] sync_q;
  logic [CntW-1:0]       cnt_q;
  logic                  filt_q;
  logic                  sync_c;

  assign sync_c = sync_q[SyncStages-1];
  assign sync_o = sync_c;
  assign filt_o = filt_q;

  // Filtered value follows sync only after FilterCycles consecutive differing edges.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], d_i};
      if (load_i) begin
        filt_q <= sync_c;
        cnt_q  <= '0;
      end else if (sync_c == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(FilterCycles - 1)) begin
        filt_q <= sync_c;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature / Gray-code step decoder: filtered A/B phases in, one-cycle
// up/down/error strobes and a saturating error count out.
module quad_step_decoder
  import qdec_pkg::*;
#(
  parameter int unsigned SyncStages   = 2,
  parameter int unsigned FilterCycles = 4,
  parameter int unsigned ErrWidth     = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                a_i,
  input  logic                b_i,
  input  logic                enable_i,
  input  logic                clear_err_i,
  output logic                up_o,
  output logic                down_o,
  output logic                err_o,
  output logic [ErrWidth-1:0] err_count_o,
  output logic [1:0]          state_o
);

  localparam int unsigned InitW = $clog2(SyncStages + 2);

  fsm_e                fsm_q;
  logic [InitW-1:0]    init_cnt_q;
  logic [1:0]          prev_q;
  logic                up_q;
  logic                down_q;
  logic                err_q;
  logic [ErrWidth-1:0] err_cnt_q;

  logic                sync_a;
  logic                sync_b;
  logic                filt_a;
  logic                filt_b;
  logic                load_c;
  logic                emit_c;
  step_e               step_c;

  glitch_filter #(
    .SyncStages  (SyncStages),
    .FilterCycles(FilterCycles)
  ) u_filt_a (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (a_i),
    .load_i(load_c),
    .sync_o(sync_a),
    .filt_o(filt_a)
  );

  glitch_filter #(
    .SyncStages  (SyncStages),
    .FilterCycles(FilterCycles)
  ) u_filt_b (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (b_i),
    .load_i(load_c),
    .sync_o(sync_b),
    .filt_o(filt_b)
  );

  // Load once the synchronisers hold post-reset pin samples.
  assign load_c = (fsm_q == S_INIT) && (init_cnt_q == InitW'(SyncStages));
  assign step_c = gray_step(prev_q, {filt_a, filt_b});
  assign emit_c = (fsm_q == S_RUN) && enable_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fsm_q      <= S_INIT;
      init_cnt_q <= '0;
      prev_q     <= 2'b00;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
      err_q  <= 1'b0;
      // On load, prev tracks the loaded level so the first run edge sees no move.
      prev_q <= load_c ? {sync_a, sync_b} : {filt_a, filt_b};

      case (fsm_q)
        S_INIT: begin
          if (load_c) begin
            fsm_q <= S_RUN;
          end else begin
            init_cnt_q <= init_cnt_q + InitW'(1);
          end
        end
        S_RUN: begin
          if (enable_i) begin
            case (step_c)
              STEP_UP:   up_q   <= 1'b1;
              STEP_DOWN: down_q <= 1'b1;
              STEP_ERR:  err_q  <= 1'b1;
              default:   ;
            endcase
          end
        end
        default: fsm_q <= S_INIT;
      endcase

      if (clear_err_i) begin
        err_cnt_q <= '0;
      end else if (emit_c && (step_c == STEP_ERR) && !(&err_cnt_q)) begin
        err_cnt_q <= err_cnt_q + ErrWidth'(1);
      end
    end
  end

  assign up_o        = up_q;
  assign down_o      = down_q;
  assign err_o       = err_q;
  assign err_count_o = err_cnt_q;
  assign state_o     = {filt_a, filt_b};

endmodule
